bfifo_rr_arb: RTL and testbench

- Round-robin arbiter sharing one buffered valid/ready slot among NREQ requesters.
- Each requester presents v/data; the arbiter grants one per cycle and loads the winner's word plus source id into a single holding register.
- The holding register drives the downstream valid/ready interface.
- Sits in front of a shared bfifo-style stage feeding a common consumer.

---
 rtl/bfifo_pkg.sv | 39 +++
 rtl/bfifo_rr_pick.sv | 38 +++
 rtl/bfifo_rr_arb.sv | 95 +++++++++
 tb/tb_bfifo_rr_arb.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bfifo_pkg.sv
// Shared constants and rotating-priority helpers for the bfifo round-robin arbiter.
// Helpers work on an 8-bit vector (the widest supported requester count).
package bfifo_pkg;

    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned DEF_DW   = 4;
    localparam int unsigned MAX_NREQ = 8;

    // One-hot of the first set bit of req, scanning upward from ptr with wrap at n-1.
    function automatic logic [7:0] rr_onehot(input logic [7:0]  req,
                                             input logic [2:0]  ptr,
                                             input int unsigned n);
        logic [7:0]  gnt;
        logic        found;
        int unsigned idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < MAX_NREQ; off++) begin
            idx = (32'(ptr) + off) % n;
            if ((off < n) && !found && req[idx[2:0]]) begin
                gnt[idx[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bfifo_rr_pick.sv
// Combinational rotating-priority picker: first requester at or above the pointer wins.
module bfifo_rr_pick
    import bfifo_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [7:0] w_req8;
    logic [2:0] w_ptr3;
    logic [7:0] w_gnt8;
    logic [2:0] w_idx3;
    logic       w_unused_idx;

    always_comb begin
        w_req8              = '0;
        w_req8[NREQ-1:0]    = i_req;
        w_ptr3              = '0;
        w_ptr3[IDW-1:0]     = i_ptr;
    end

    assign w_gnt8 = rr_onehot(w_req8, w_ptr3, NREQ);
    assign w_idx3 = onehot_to_idx(w_gnt8);

    assign o_gnt = w_gnt8[NREQ-1:0];
    assign o_idx = w_idx3[IDW-1:0];
    assign o_any = |w_gnt8;

    // Upper index bits are always zero for small NREQ.
    assign w_unused_idx = ^w_idx3;

endmodule

// File: rtl/bfifo_rr_arb.sv
// Round-robin arbiter loading one shared holding register that drives a valid/ready output.
// Optional burst lock (input lock) is enabled by defining BFIFO_ARB_LOCK_EN.
module bfifo_rr_arb
    import bfifo_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    v_in,
    input  logic [NREQ*DW-1:0] data_in,
    output logic [NREQ-1:0]    r_out,
    output logic               v_out,
    output logic [DW-1:0]      data_out,
    output logic [IDW-1:0]     id_out,
    input  logic               r_in
`ifdef BFIFO_ARB_LOCK_EN
    ,
    input  logic [NREQ-1:0]    lock
`endif
);

    logic            r_full;
    logic [DW-1:0]   r_data;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  r_ptr;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_can_accept;
    logic            w_up;
    logic            w_lock_hit;
    logic [IDW-1:0]  w_ptr_adv;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [DW-1:0]   w_sel;

    bfifo_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req (v_in),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Slot refills on the same edge it drains, so a ready downstream never sees a bubble.
    assign w_can_accept = ~r_full | r_in;
    assign w_up         = w_any & w_can_accept;
    assign r_out        = w_gnt & {NREQ{w_can_accept & reset}};

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel = data_in[i*DW +: DW];
            end
        end
    end

`ifdef BFIFO_ARB_LOCK_EN
    assign w_lock_hit = |(lock & w_gnt);
`else
    assign w_lock_hit = 1'b0;
`endif

    assign w_ptr_adv = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    // A locked winner keeps the pointer on itself so its burst keeps priority.
    assign w_ptr_nxt = w_lock_hit ? w_idx : w_ptr_adv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
        end else if (w_up) begin
            r_full <= 1'b1;
            r_data <= w_sel;
            r_id   <= w_idx;
            r_ptr  <= w_ptr_nxt;
        end else if (r_full && r_in) begin
            r_full <= 1'b0;
        end
    end

    assign v_out    = r_full;
    assign data_out = r_data;
    assign id_out   = r_id;

endmodule

// File: tb/tb_bfifo_rr_arb.sv
// Directed self-checking bench for bfifo_rr_arb (NREQ=4, DW=4).
module tb_bfifo_rr_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 4;
    localparam int unsigned IDW  = 2;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    v_in;
    logic [NREQ*DW-1:0] data_in;
    logic [NREQ-1:0]    r_out;
    logic               v_out;
    logic [DW-1:0]      data_out;
    logic [IDW-1:0]     id_out;
    logic               r_in;
`ifdef BFIFO_ARB_LOCK_EN
    logic [NREQ-1:0]    lock;
`endif

    int checks;
    int errors;

    bfifo_rr_arb #(
        .NREQ (NREQ),
        .DW   (DW),
        .IDW  (IDW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .v_in     (v_in),
        .data_in  (data_in),
        .r_out    (r_out),
        .v_out    (v_out),
        .data_out (data_out),
        .id_out   (id_out),
        .r_in     (r_in)
`ifdef BFIFO_ARB_LOCK_EN
        ,
        .lock     (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the registered slot contents after an edge.
    task automatic slot(input string tag, input logic v, input logic [3:0] d, input logic [1:0] id);
        check({tag, ".v"}, 32'(v_out), 32'(v));
        check({tag, ".d"}, 32'(data_out), 32'(d));
        check({tag, ".id"}, 32'(id_out), 32'(id));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        v_in    = 4'b1111;
        r_in    = 1'b0;
        data_in = {4'd4, 4'd3, 4'd2, 4'd1};
`ifdef BFIFO_ARB_LOCK_EN
        lock    = '0;
`endif
        #2;
        slot("rst", 1'b0, 4'd0, 2'd0);
        check("rst.r_out", 32'(r_out), 32'h0);
        step();
        step();

        // Fairness: all requesting, downstream always ready
        reset = 1'b1;
        r_in  = 1'b1;
        #1;
        check("fair.r0", 32'(r_out), 32'b0001);
        step(); slot("fair0", 1'b1, 4'd1, 2'd0);
        check("fair.r1", 32'(r_out), 32'b0010);
        step(); slot("fair1", 1'b1, 4'd2, 2'd1);
        step(); slot("fair2", 1'b1, 4'd3, 2'd2);
        step(); slot("fair3", 1'b1, 4'd4, 2'd3);
        step(); slot("fair4", 1'b1, 4'd1, 2'd0);

        // Back-pressure: load req 2 with data 5, then stall
        v_in    = 4'b0100;
        data_in = {4'd4, 4'd5, 4'd2, 4'd1};
        step(); slot("bp.load", 1'b1, 4'd5, 2'd2);
        r_in = 1'b0;
        v_in = 4'b1111;
        #1;
        check("bp.r_out0", 32'(r_out), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            slot("bp.hold", 1'b1, 4'd5, 2'd2);
            check("bp.r_out", 32'(r_out), 32'h0);
        end
        r_in = 1'b1;
        #1;
        check("bp.resume", 32'(r_out), 32'b1000);
        step(); slot("bp.next", 1'b1, 4'd4, 2'd3);

        // Simultaneous drain/fill: hold id 1, then req 0 loads on the draining edge
        v_in = 4'b0010;
        step(); slot("sim.fill", 1'b1, 4'd2, 2'd1);
        v_in = 4'b0001;
        #1;
        check("sim.r_out", 32'(r_out), 32'b0001);
        step(); slot("sim.swap", 1'b1, 4'd1, 2'd0);

        // Sparse/wrap: bring pointer to 3, then only reqs 3 and 0
        v_in = 4'b0100;
        step(); slot("wrap.pre", 1'b1, 4'd5, 2'd2);
        v_in = 4'b1001;
        #1;
        check("wrap.r3", 32'(r_out), 32'b1000);
        step(); slot("wrap.a", 1'b1, 4'd4, 2'd3);
        check("wrap.r0", 32'(r_out), 32'b0001);
        step(); slot("wrap.b", 1'b1, 4'd1, 2'd0);
        step(); slot("wrap.c", 1'b1, 4'd4, 2'd3);
        v_in = 4'b0000;
        step(); slot("idle.a", 1'b0, 4'd4, 2'd3);
        step(); slot("idle.b", 1'b0, 4'd4, 2'd3);
        v_in = 4'b1001;
        #1;
        check("idle.ptr", 32'(r_out), 32'b0001);

        // Reset mid-stream with the slot full and stalled
        step(); slot("mid.full", 1'b1, 4'd1, 2'd0);
        r_in = 1'b0;
        v_in = 4'b1111;
        #2;
        reset = 1'b0;
        #1;
        slot("mid.rst", 1'b0, 4'd0, 2'd0);
        check("mid.r_out", 32'(r_out), 32'h0);
        #3;
        reset = 1'b1;
        r_in  = 1'b1;
        #1;
        check("post.r_out", 32'(r_out), 32'b0001);
        step(); slot("post.first", 1'b1, 4'd1, 2'd0);

`ifdef BFIFO_ARB_LOCK_EN
        // Lock: req 1 keeps priority for three words, then normal advance resumes
        lock = 4'b0010;
        #1;
        check("lock.r_out", 32'(r_out), 32'b0010);
        step(); slot("lock.a", 1'b1, 4'd2, 2'd1);
        step(); slot("lock.b", 1'b1, 4'd2, 2'd1);
        step(); slot("lock.c", 1'b1, 4'd2, 2'd1);
        lock = 4'b0000;
        step(); slot("lock.d", 1'b1, 4'd2, 2'd1);
        check("lock.next", 32'(r_out), 32'b0100);
        step(); slot("lock.e", 1'b1, 4'd5, 2'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
